uart_rx_sampler: RTL and testbench

- UART receiver consuming the 16x oversample clock from the baud-rate generator (BaudIn = its baud_out toggle output).
- Synchronises Rx, detects the start bit, samples each bit at mid-bit, optionally checks parity, checks the stop bit.
- Presents the received byte plus error flags on a valid/ready output register read by the bus-side register block.

---
 rtl/uart_rx_sampler_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx_sampler.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_sampler_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, default geometry,
// baud divider constants shared with the baud generator, and a 3-input vote helper.
package uart_rx_sampler_pkg;

   localparam int unsigned DEFAULT_DATA_BITS  = 8;
   localparam int unsigned DEFAULT_OVERSAMPLE = 16;

   // Divider settings understood by the baud-rate generator.
   localparam logic [11:0] BAUD_DIV_230400 = 12'h364;
   localparam logic [11:0] BAUD_DIV_115200 = 12'h6C8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } rx_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Rx double-flop synchronizer and BaudIn edge detector; tick_c is high for one
// Clock on every BaudIn transition.
module uart_rx_sync (
   input  logic Clock,
   input  logic Reset,
   input  logic rx,
   input  logic baud_in,
   output logic rx_s,
   output logic tick_c
);

   logic rx_meta;
   logic baud_q;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         baud_q  <= 1'b0;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         baud_q  <= baud_in;
      end
   end

   assign tick_c = baud_in ^ baud_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receiver: oversampled start detect, mid-bit sampling, parity/stop checks and a
// valid/ready output register. Define UART_RX_MAJORITY_VOTE_EN for 3-sample bit voting.
module uart_rx_sampler
   import uart_rx_sampler_pkg::*;
#(
   parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
   parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Enable,
   input  logic       BaudIn,
   input  logic       Rx,
   input  logic       ParityEn,
   input  logic       ParityOdd,
   output logic [7:0] Data,
   output logic       Valid,
   input  logic       Ready,
   output logic       ParityErr,
   output logic       FramingErr,
   output logic       OverrunErr,
   output logic       Busy
);

   localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned BCNT_W = 3;
   localparam int unsigned MID    = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_VOTE_EN
   // Decide one tick after mid so the vote window is mid-1, mid, mid+1.
   localparam int unsigned START_PT = MID + 1;
`else
   localparam int unsigned START_PT = MID;
`endif
   localparam logic [TCNT_W-1:0] START_LAST = TCNT_W'(START_PT);
   localparam logic [TCNT_W-1:0] BIT_LAST   = TCNT_W'(OVERSAMPLE - 1);
   localparam logic [BCNT_W-1:0] BCNT_LAST  = BCNT_W'(DATA_BITS - 1);

   logic rx_s;
   logic tick_c;
   logic bit_val;

   uart_rx_sync u_sync (
      .Clock   (Clock),
      .Reset   (Reset),
      .rx      (Rx),
      .baud_in (BaudIn),
      .rx_s    (rx_s),
      .tick_c  (tick_c)
   );

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic [1:0] hist;

   // Previous two tick samples of the synchronised line.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)      hist <= 2'b11;
      else if (tick_c) hist <= {hist[0], rx_s};
   end

   assign bit_val = maj3(hist[1], hist[0], rx_s);
`else
   assign bit_val = rx_s;
`endif

   rx_state_t             state, state_n;
   logic [TCNT_W-1:0]     tcnt, tcnt_n;
   logic [BCNT_W-1:0]     bcnt, bcnt_n;
   logic [DATA_BITS-1:0]  shift, shift_n;
   logic                  par_en_q, par_en_n;
   logic                  par_odd_q, par_odd_n;
   logic                  par_err_q, par_err_n;
   logic [7:0]            data_n;
   logic                  valid_n, pe_n, fe_n, ovr_n;
   logic                  frame_done, frame_fe;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state      <= ST_IDLE;
         tcnt       <= '0;
         bcnt       <= '0;
         shift      <= '0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         par_err_q  <= 1'b0;
         Data       <= '0;
         Valid      <= 1'b0;
         ParityErr  <= 1'b0;
         FramingErr <= 1'b0;
         OverrunErr <= 1'b0;
         Busy       <= 1'b0;
      end else begin
         state      <= state_n;
         tcnt       <= tcnt_n;
         bcnt       <= bcnt_n;
         shift      <= shift_n;
         par_en_q   <= par_en_n;
         par_odd_q  <= par_odd_n;
         par_err_q  <= par_err_n;
         Data       <= data_n;
         Valid      <= valid_n;
         ParityErr  <= pe_n;
         FramingErr <= fe_n;
         OverrunErr <= ovr_n;
         Busy       <= (state_n != ST_IDLE);
      end
   end

   // Frame FSM: advances only on oversample ticks.
   always_comb begin
      state_n    = state;
      tcnt_n     = tcnt;
      bcnt_n     = bcnt;
      shift_n    = shift;
      par_en_n   = par_en_q;
      par_odd_n  = par_odd_q;
      par_err_n  = par_err_q;
      frame_done = 1'b0;
      frame_fe   = 1'b0;

      if (!Enable) begin
         state_n = ST_IDLE;
         tcnt_n  = '0;
         bcnt_n  = '0;
      end else if (tick_c) begin
         case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_n = ST_START;
                  tcnt_n  = '0;
               end
            end
            ST_START: begin
               if (tcnt == START_LAST) begin
                  tcnt_n = '0;
                  if (!bit_val) begin
                     state_n   = ST_DATA;
                     bcnt_n    = '0;
                     par_en_n  = ParityEn;
                     par_odd_n = ParityOdd;
                     par_err_n = 1'b0;
                  end else begin
                     state_n = ST_IDLE;
                  end
               end else begin
                  tcnt_n = tcnt + TCNT_W'(1);
               end
            end
            ST_DATA: begin
               if (tcnt == BIT_LAST) begin
                  tcnt_n        = '0;
                  shift_n[bcnt] = bit_val;
                  if (bcnt == BCNT_LAST) state_n = par_en_q ? ST_PARITY : ST_STOP;
                  else                   bcnt_n  = bcnt + BCNT_W'(1);
               end else begin
                  tcnt_n = tcnt + TCNT_W'(1);
               end
            end
            ST_PARITY: begin
               if (tcnt == BIT_LAST) begin
                  tcnt_n    = '0;
                  par_err_n = ((^shift) ^ bit_val) != par_odd_q;
                  state_n   = ST_STOP;
               end else begin
                  tcnt_n = tcnt + TCNT_W'(1);
               end
            end
            ST_STOP: begin
               if (tcnt == BIT_LAST) begin
                  tcnt_n     = '0;
                  frame_done = 1'b1;
                  frame_fe   = !bit_val;
                  state_n    = bit_val ? ST_IDLE : ST_BREAK;
               end else begin
                  tcnt_n = tcnt + TCNT_W'(1);
               end
            end
            ST_BREAK: begin
               if (rx_s) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   // Output register and valid/ready handshake; a busy register drops the new frame.
   always_comb begin
      data_n  = Data;
      valid_n = Valid;
      pe_n    = ParityErr;
      fe_n    = FramingErr;
      ovr_n   = 1'b0;

      if (frame_done) begin
         if (!Valid || Ready) begin
            data_n  = 8'(shift);
            pe_n    = par_err_q;
            fe_n    = frame_fe;
            valid_n = 1'b1;
         end else begin
            ovr_n = 1'b1;
         end
      end else if (Valid && Ready) begin
         valid_n = 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: frames are driven bit-serially and the
// received outputs are compared against values computed from the frame contents.
module tb_uart_rx_sampler;

   localparam int unsigned CLK_PER_TICK = 4;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       Enable = 1'b1;
   logic       BaudIn = 1'b0;
   logic       Rx = 1'b1;
   logic       ParityEn = 1'b0;
   logic       ParityOdd = 1'b0;
   logic [7:0] Data;
   logic       Valid;
   logic       Ready = 1'b1;
   logic       ParityErr;
   logic       FramingErr;
   logic       OverrunErr;
   logic       Busy;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } frame_t;

   frame_t rcv_q[$];
   frame_t mon_f;
   int     ovr_cnt = 0;
   int     n_cmp = 0;
   int     n_fail = 0;

   uart_rx_sampler dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Enable     (Enable),
      .BaudIn     (BaudIn),
      .Rx         (Rx),
      .ParityEn   (ParityEn),
      .ParityOdd  (ParityOdd),
      .Data       (Data),
      .Valid      (Valid),
      .Ready      (Ready),
      .ParityErr  (ParityErr),
      .FramingErr (FramingErr),
      .OverrunErr (OverrunErr),
      .Busy       (Busy)
   );

   always #10 Clock = ~Clock;

   initial begin
      forever begin
         repeat (CLK_PER_TICK) @(negedge Clock);
         BaudIn = ~BaudIn;
      end
   end

   // Record every accepted frame and every overrun-cycle.
   initial begin
      forever begin
         @(negedge Clock);
         #1;
         if (Reset && Valid && Ready) begin
            mon_f.d  = Data;
            mon_f.pe = ParityErr;
            mon_f.fe = FramingErr;
            rcv_q.push_back(mon_f);
         end
         if (OverrunErr) ovr_cnt++;
      end
   end

   function automatic bit exp_pe(input logic [7:0] d, input bit pen, input bit odd, input bit pbit);
      int ones;
      ones = $countones(d) + int'(pbit);
      return pen && ((ones % 2) != int'(odd));
   endfunction

   task automatic wait_ticks(input int n);
      repeat (n * CLK_PER_TICK) @(negedge Clock);
   endtask

   // Drive one frame; gbit selects a data bit that gets a short inverted glitch at mid-bit.
   task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit, input int gbit);
      Rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         Rx = d[i];
         if (i == gbit) begin
            repeat (32) @(negedge Clock);
            Rx = ~d[i];
            repeat (3) @(negedge Clock);
            Rx = d[i];
            repeat (29) @(negedge Clock);
         end else begin
            wait_ticks(16);
         end
      end
      if (pen) begin
         Rx = pbit;
         wait_ticks(16);
      end
      Rx = 1'b1;
      wait_ticks(16);
   endtask

   task automatic test_reset;
      Reset = 1'b0;
      repeat (4) @(negedge Clock);
      Reset = 1'b1;
      repeat (4) @(negedge Clock);
      n_cmp++; if (Data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h want 0", Data); end
      n_cmp++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", Valid); end
      n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
      n_cmp++; if ({ParityErr, FramingErr, OverrunErr} !== 3'b000)
         begin n_fail++; $display("FAIL reset_flags: got %b want 000", {ParityErr, FramingErr, OverrunErr}); end
   endtask

   task automatic test_8n1;
      rcv_q.delete();
      ParityEn = 1'b0;
      send_frame(8'hA5, 1'b0, 1'b0, -1);
      wait_ticks(4);
      n_cmp++; if (rcv_q.size() !== 1) begin n_fail++; $display("FAIL a5_count: got %0d want 1", rcv_q.size()); end
      if (rcv_q.size() > 0) begin
         n_cmp++; if (rcv_q[0].d !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %0h want a5", rcv_q[0].d); end
         n_cmp++; if ({rcv_q[0].pe, rcv_q[0].fe} !== 2'b00)
            begin n_fail++; $display("FAIL a5_flags: got %b want 00", {rcv_q[0].pe, rcv_q[0].fe}); end
      end
      n_cmp++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL a5_valid_drop: got %b want 0", Valid); end
   endtask

   task automatic test_parity;
      logic [1:0] pbits;
      pbits = 2'b10;
      for (int k = 0; k < 2; k++) begin
         rcv_q.delete();
         ParityEn  = 1'b1;
         ParityOdd = 1'b0;
         send_frame(8'h07, 1'b1, pbits[k], -1);
         wait_ticks(4);
         n_cmp++; if (rcv_q.size() !== 1) begin n_fail++; $display("FAIL par_count[%0d]: got %0d want 1", k, rcv_q.size()); end
         if (rcv_q.size() > 0) begin
            n_cmp++; if (rcv_q[0].d !== 8'h07) begin n_fail++; $display("FAIL par_data[%0d]: got %0h want 07", k, rcv_q[0].d); end
            n_cmp++; if (rcv_q[0].pe !== (k == 0))
               begin n_fail++; $display("FAIL par_err[%0d]: got %b want %b", k, rcv_q[0].pe, k == 0); end
         end
      end
      ParityEn = 1'b0;
   endtask

   task automatic test_random;
      logic [7:0] d;
      bit pen, odd, pbit, pe;
      for (int k = 0; k < 8; k++) begin
         d    = 8'($urandom);
         pen  = 1'($urandom_range(0, 1));
         odd  = 1'($urandom_range(0, 1));
         pbit = 1'($urandom_range(0, 1));
         pe   = exp_pe(d, pen, odd, pbit);
         rcv_q.delete();
         ParityEn  = pen;
         ParityOdd = odd;
         send_frame(d, pen, pbit, -1);
         wait_ticks(4);
         n_cmp++; if (rcv_q.size() !== 1) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want 1", k, rcv_q.size()); end
         if (rcv_q.size() > 0) begin
            n_cmp++; if ({rcv_q[0].d, rcv_q[0].pe, rcv_q[0].fe} !== {d, pe, 1'b0})
               begin n_fail++; $display("FAIL rnd_frame[%0d]: got d=%0h pe=%b fe=%b want d=%0h pe=%b fe=0",
                                         k, rcv_q[0].d, rcv_q[0].pe, rcv_q[0].fe, d, pe); end
         end
      end
      ParityEn  = 1'b0;
      ParityOdd = 1'b0;
   endtask

   task automatic test_glitch;
      rcv_q.delete();
      Rx = 1'b0;
      wait_ticks(3);
      n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_on: got %b want 1", Busy); end
      wait_ticks(2);
      Rx = 1'b1;
      wait_ticks(7);
      n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_off: got %b want 0", Busy); end
      wait_ticks(160);
      n_cmp++; if (rcv_q.size() !== 0) begin n_fail++; $display("FAIL glitch_frames: got %0d want 0", rcv_q.size()); end
   endtask

   task automatic test_break;
      rcv_q.delete();
      Rx = 1'b0;
      wait_ticks(30 * 16);
      Rx = 1'b1;
      wait_ticks(16);
      n_cmp++; if (rcv_q.size() !== 1) begin n_fail++; $display("FAIL break_count: got %0d want 1", rcv_q.size()); end
      if (rcv_q.size() > 0) begin
         n_cmp++; if ({rcv_q[0].d, rcv_q[0].fe} !== {8'h00, 1'b1})
            begin n_fail++; $display("FAIL break_frame: got d=%0h fe=%b want d=0 fe=1", rcv_q[0].d, rcv_q[0].fe); end
      end
      rcv_q.delete();
      send_frame(8'h3C, 1'b0, 1'b0, -1);
      wait_ticks(4);
      n_cmp++; if (rcv_q.size() !== 1) begin n_fail++; $display("FAIL post_break_count: got %0d want 1", rcv_q.size()); end
      if (rcv_q.size() > 0) begin
         n_cmp++; if ({rcv_q[0].d, rcv_q[0].pe, rcv_q[0].fe} !== {8'h3C, 2'b00})
            begin n_fail++; $display("FAIL post_break_frame: got d=%0h pe=%b fe=%b want d=3c clean",
                                      rcv_q[0].d, rcv_q[0].pe, rcv_q[0].fe); end
      end
   endtask

   task automatic test_back_to_back;
      rcv_q.delete();
      Ready   = 1'b0;
      ovr_cnt = 0;
      send_frame(8'h11, 1'b0, 1'b0, -1);
      send_frame(8'h22, 1'b0, 1'b0, -1);
      wait_ticks(4);
      n_cmp++; if (Data !== 8'h11) begin n_fail++; $display("FAIL ovr_data: got %0h want 11", Data); end
      n_cmp++; if (Valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", Valid); end
      n_cmp++; if (ovr_cnt !== 1) begin n_fail++; $display("FAIL ovr_pulse_cycles: got %0d want 1", ovr_cnt); end
      Ready = 1'b1;
      repeat (3) @(negedge Clock);
      #1;
      n_cmp++; if (rcv_q.size() !== 1) begin n_fail++; $display("FAIL ovr_drain_count: got %0d want 1", rcv_q.size()); end
      if (rcv_q.size() > 0) begin
         n_cmp++; if (rcv_q[0].d !== 8'h11) begin n_fail++; $display("FAIL ovr_drain_data: got %0h want 11", rcv_q[0].d); end
      end
      n_cmp++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_drop: got %b want 0", Valid); end
   endtask

   task automatic test_enable;
      rcv_q.delete();
      Rx = 1'b0;
      wait_ticks(16);
      Rx = 1'b1;
      wait_ticks(32);
      Enable = 1'b0;
      repeat (2) @(negedge Clock);
      n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL enable_busy: got %b want 0", Busy); end
      wait_ticks(7 * 16);
      Enable = 1'b1;
      wait_ticks(32);
      n_cmp++; if (rcv_q.size() !== 0) begin n_fail++; $display("FAIL enable_frames: got %0d want 0", rcv_q.size()); end
   endtask

   task automatic test_reset_midframe;
      rcv_q.delete();
      Rx = 1'b0;
      wait_ticks(16);
      Rx = 1'b1;
      wait_ticks(4 * 16 + 8);
      Reset = 1'b0;
      #1;
      n_cmp++; if ({Valid, Busy} !== 2'b00) begin n_fail++; $display("FAIL midrst_outputs: got %b want 00", {Valid, Busy}); end
      n_cmp++; if (Data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %0h want 0", Data); end
      repeat (3) @(negedge Clock);
      Reset = 1'b1;
      wait_ticks(32);
      send_frame(8'h5A, 1'b0, 1'b0, -1);
      wait_ticks(4);
      n_cmp++; if (rcv_q.size() !== 1) begin n_fail++; $display("FAIL midrst_count: got %0d want 1", rcv_q.size()); end
      if (rcv_q.size() > 0) begin
         n_cmp++; if (rcv_q[0].d !== 8'h5A) begin n_fail++; $display("FAIL midrst_frame: got %0h want 5a", rcv_q[0].d); end
      end
`ifdef UART_RX_MAJORITY_VOTE_EN
      rcv_q.delete();
      send_frame(8'h5A, 1'b0, 1'b0, 3);
      wait_ticks(4);
      n_cmp++; if (rcv_q.size() !== 1) begin n_fail++; $display("FAIL vote_count: got %0d want 1", rcv_q.size()); end
      if (rcv_q.size() > 0) begin
         n_cmp++; if (rcv_q[0].d !== 8'h5A) begin n_fail++; $display("FAIL vote_frame: got %0h want 5a", rcv_q[0].d); end
      end
`endif
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_random();
      test_glitch();
      test_break();
      test_back_to_back();
      test_enable();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
